alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream/downstream wrapper stage for the combinational 4-bit signed/unsigned ALU.
- Buffers incoming ALU commands {select, a, b} in a small FIFO, presents the head command to the ALU, and captures the ALU result and flags into a registered response stage with a valid/ready handshake.
- Also keeps sticky carry/overflow status, a divide-by-zero error flag per response, and a wrapping completed-operation counter for the system controller.

Parameters:
- DEPTH, 4, command FIFO depth; power of two, 2..16.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_sel  in  3  ALU operation: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not.
- cmd_a  in  4  operand a, two's complement.
- cmd_b  in  4  operand b, two's complement.
- alu_select  out  3  head command select to ALU.
- alu_a  out  4  head operand a to ALU.
- alu_b  out  4  head operand b to ALU.
- alu_out  in  4  ALU result.
- alu_flags  in  5  ALU flags {carry, overflow, parity, zero, sign}.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  4  captured result.
- rsp_flags  out  5  captured {carry, overflow, parity, zero, sign}.
- rsp_err  out  1  captured command was div with b==0.
- sticky_carry  out  1  OR of carry over all captures since last clear.
- sticky_ovf  out  1  OR of overflow over all captures since last clear.
- sticky_clr  in  1  synchronous clear of sticky bits.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- op_count  out  CNT_W  completed captures, wraps at 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and level = 0; rsp_valid, rsp_data, rsp_flags, rsp_err = 0; sticky bits = 0; op_count = 0; FSM = IDLE.
- Reset asserted mid-operation discards all queued commands and any held response. No response is emitted for those commands after reset release.

Push:
- Push when cmd_valid && cmd_ready.
- Full (level==DEPTH) drives cmd_ready=0; no push, even if a pop occurs in the same cycle.

ALU drive:
- alu_select/alu_a/alu_b come combinationally from the FIFO head register when level>0; all zero when empty.
- The ALU is purely combinational, so its result is valid the same cycle.

Capture:
- cap = (level>0) && (!rsp_valid || rsp_ready).
- On cap: rsp_data<=alu_out; rsp_flags<=alu_flags; rsp_err<=(alu_select==3 && alu_b==0); rsp_valid<=1; FIFO pop; op_count<=op_count+1 (wraps).
- If rsp_valid && rsp_ready && !cap: rsp_valid<=0; data and flags hold their last value.
- If rsp_valid && !rsp_ready: response and FIFO head frozen; the ALU keeps seeing the same head.

Sticky bits:
- On cap, sticky_carry |= carry and sticky_ovf |= overflow.
- If sticky_clr and cap occur in the same cycle, the new capture wins: sticky = new flag value only.

Occupancy:
- Simultaneous push and pop: level unchanged, pointers both advance. Pointers wrap modulo DEPTH.

Latency:
- A command pushed in cycle N into an empty FIFO is at the head in N+1, captured at the end of N+1, and rsp_valid is high in N+2.
- Steady-state throughput is 1 response/cycle while rsp_ready=1.

FSM (response stage):
- IDLE (rsp_valid=0): → FULL on cap.
- FULL (rsp_valid=1): stays FULL on cap; → IDLE on rsp_ready && !cap; holds on !rsp_ready.

Decomposition:
- Shared package alu_pkg:
  - localparams for opcode encodings ALU_ADD..ALU_NOT;
  - flag bit indices FLG_CARRY=4, FLG_OVF=3, FLG_PAR=2, FLG_ZERO=1, FLG_SIGN=0;
  - packed command type {sel[2:0], a[3:0], b[3:0]} (11 bits).
- One natural sub-module: cmd_fifo (synchronous FIFO with level output, parameter DEPTH, width 11). Sequencer FSM, capture and sticky logic live in the top.
- The bench instantiates the real ALU between the alu_* ports.

Test Plan:
- Reset then push add a=3, b=4 with rsp_ready=1 → rsp_valid exactly 2 cycles after push; rsp_data=7; flags carry=0, ovf=0, zero=0, sign=0, parity=0; op_count=1.
- Push add 7+1, then sub 0-1 → rsp_data=8 with ovf=1 (sticky_ovf=1), then rsp_data=0xF with carry=1 (sticky_carry=1). Pulse sticky_clr → both stickies 0.
- Hold rsp_ready=0 and push 5 commands (DEPTH=4) → cmd_ready=0 once level=4; response frozen on the first command. Release rsp_ready → the 4 queued responses come out in order at 1/cycle, level decrements to 0, op_count=5.
- Push div a=5, b=0 → rsp_err=1; ovf=1.
- Push div 6/2 → rsp_err=0.
- With level=2 and rsp_valid=1, assert rst_n=0 for 1 cycle → all outputs 0 immediately and no stale response after release. sticky_clr coincident with an overflowing capture → sticky_ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the packed
// command word carried through the sequencer FIFO.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_MUL = 3'd2;
   localparam logic [2:0] ALU_DIV = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_XOR = 3'd6;
   localparam logic [2:0] ALU_NOT = 3'd7;

   localparam int FLG_CARRY = 4;
   localparam int FLG_OVF   = 3;
   localparam int FLG_PAR   = 2;
   localparam int FLG_ZERO  = 1;
   localparam int FLG_SIGN  = 0;

   typedef struct packed {
      logic [2:0] sel;
      logic [3:0] a;
      logic [3:0] b;
   } alu_cmd_t;

   localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with occupancy output; head entry is visible on rdata
// whenever the FIFO is non-empty.
module cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CMD_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [AW:0]  level,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset: reads are only meaningful while level > 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives the head to the combinational ALU and registers
// its result into a valid/ready response stage with sticky status and a count.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_sel,
   input  logic [3:0]               cmd_a,
   input  logic [3:0]               cmd_b,
   output logic [2:0]               alu_select,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   input  logic [3:0]               alu_out,
   input  logic [4:0]               alu_flags,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [3:0]               rsp_data,
   output logic [4:0]               rsp_flags,
   output logic                     rsp_err,
   output logic                     sticky_carry,
   output logic                     sticky_ovf,
   input  logic                     sticky_clr,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         op_count
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_FULL = 1'b1;

   alu_cmd_t   wcmd, head;
   logic       full, empty, cap;
   logic [0:0] state;

   assign wcmd = '{sel: cmd_sel, a: cmd_a, b: cmd_b};

   cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .pop   (cap),
      .wdata (wcmd),
      .rdata (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   assign cmd_ready  = !full;
   assign alu_select = empty ? 3'd0 : head.sel;
   assign alu_a      = empty ? 4'd0 : head.a;
   assign alu_b      = empty ? 4'd0 : head.b;

   assign rsp_valid = (state == S_FULL);
   assign cap       = !empty && (!rsp_valid || rsp_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
         op_count  <= '0;
      end else if (cap) begin
         state     <= S_FULL;
         rsp_data  <= alu_out;
         rsp_flags <= alu_flags;
         rsp_err   <= (alu_select == ALU_DIV) && (alu_b == 4'd0);
         op_count  <= op_count + 1'b1;
      end else if (rsp_valid && rsp_ready) begin
         state <= S_IDLE;
      end
   end

   // A clear coincident with a capture leaves only the newly captured flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_carry <= 1'b0;
         sticky_ovf   <= 1'b0;
      end else if (cap) begin
         sticky_carry <= (sticky_carry && !sticky_clr) || alu_flags[FLG_CARRY];
         sticky_ovf   <= (sticky_ovf && !sticky_clr) || alu_flags[FLG_OVF];
      end else if (sticky_clr) begin
         sticky_carry <= 1'b0;
         sticky_ovf   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU wired
// between the alu_* ports.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_sel;
   logic [3:0] cmd_a, cmd_b;
   logic [2:0] alu_select;
   logic [3:0] alu_a, alu_b, alu_out;
   logic [4:0] alu_flags;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_data;
   logic [4:0] rsp_flags;
   logic       rsp_err, sticky_carry, sticky_ovf, sticky_clr;
   logic [2:0] level;
   logic [7:0] op_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
      .level(level), .op_count(op_count)
   );

   // Behavioural ALU; flags {carry, overflow, even-parity, zero, sign}
   logic [3:0]        r;
   logic              fc, fo;
   logic [4:0]        sum5;
   logic signed [7:0] sa, sb, prod, quo;
   always_comb begin
      r = 4'd0; fc = 1'b0; fo = 1'b0; sum5 = 5'd0; prod = 8'sd0; quo = 8'sd0;
      sa = {{4{alu_a[3]}}, alu_a};
      sb = {{4{alu_b[3]}}, alu_b};
      case (alu_select)
         3'd0: begin
            sum5 = {1'b0, alu_a} + {1'b0, alu_b};
            r = sum5[3:0]; fc = sum5[4];
            fo = (alu_a[3] == alu_b[3]) && (r[3] != alu_a[3]);
         end
         3'd1: begin
            r = alu_a - alu_b; fc = (alu_a < alu_b);
            fo = (alu_a[3] != alu_b[3]) && (r[3] != alu_a[3]);
         end
         3'd2: begin
            prod = sa * sb; r = prod[3:0];
            fo = (prod != {{4{r[3]}}, r});
         end
         3'd3: begin
            if (alu_b == 4'd0) fo = 1'b1;
            else begin
               quo = sa / sb; r = quo[3:0];
               fo = (quo != {{4{r[3]}}, r});
            end
         end
         3'd4: r = alu_a & alu_b;
         3'd5: r = alu_a | alu_b;
         3'd6: r = alu_a ^ alu_b;
         default: r = ~alu_a;
      endcase
      alu_out   = r;
      alu_flags = {fc, fo, ~^r, (r == 4'd0), r[3]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
      cmd_sel = s; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0] sel;
      logic [3:0] a, b, d;
      logic [4:0] f;
      logic       e;
   } vec_t;

   vec_t tv[14];
   logic exp_sc, exp_so;

   initial begin
      tv[0]  = '{3'd0, 4'h3, 4'h4, 4'h7, 5'b00000, 1'b0}; // add 3+4
      tv[1]  = '{3'd0, 4'h7, 4'h1, 4'h8, 5'b01001, 1'b0}; // add 7+1 ovf
      tv[2]  = '{3'd1, 4'h0, 4'h1, 4'hF, 5'b10101, 1'b0}; // sub 0-1 borrow
      tv[3]  = '{3'd2, 4'h3, 4'h3, 4'h9, 5'b01101, 1'b0}; // mul 3*3 ovf
      tv[4]  = '{3'd2, 4'h2, 4'hD, 4'hA, 5'b00101, 1'b0}; // mul 2*-3
      tv[5]  = '{3'd3, 4'h5, 4'h0, 4'h0, 5'b01110, 1'b1}; // div by zero
      tv[6]  = '{3'd3, 4'h6, 4'h2, 4'h3, 5'b00100, 1'b0}; // div 6/2
      tv[7]  = '{3'd4, 4'hC, 4'hA, 4'h8, 5'b00001, 1'b0}; // and
      tv[8]  = '{3'd5, 4'h5, 4'hA, 4'hF, 5'b00101, 1'b0}; // or
      tv[9]  = '{3'd6, 4'hF, 4'hF, 4'h0, 5'b00110, 1'b0}; // xor
      tv[10] = '{3'd7, 4'h5, 4'h0, 4'hA, 5'b00101, 1'b0}; // not
      tv[11] = '{3'd0, 4'h8, 4'h8, 4'h0, 5'b11110, 1'b0}; // -8 + -8
      tv[12] = '{3'd1, 4'h8, 4'h1, 4'h7, 5'b01000, 1'b0}; // -8 - 1
      tv[13] = '{3'd3, 4'h8, 4'hF, 4'h8, 5'b01001, 1'b0}; // -8 / -1

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
      rsp_ready = 1'b1; sticky_clr = 1'b0;
      step(); step();
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_op_count", 32'(op_count), 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_sticky", 32'({sticky_carry, sticky_ovf}), 0);
      chk("rst_rsp", 32'({rsp_data, rsp_flags, rsp_err}), 0);
      chk("rst_alu_drive", 32'({alu_select, alu_a, alu_b}), 0);
      rst_n = 1'b1;
      step();

      // Single commands: response appears exactly two cycles after the push.
      exp_sc = 1'b0; exp_so = 1'b0;
      for (int i = 0; i < 14; i++) begin
         push(tv[i].sel, tv[i].a, tv[i].b);
         chk($sformatf("v%0d_not_yet_valid", i), 32'(rsp_valid), 0);
         chk($sformatf("v%0d_level_1", i), 32'(level), 1);
         step();
         exp_sc |= tv[i].f[4];
         exp_so |= tv[i].f[3];
         chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 1);
         chk($sformatf("v%0d_data", i), 32'(rsp_data), 32'(tv[i].d));
         chk($sformatf("v%0d_flags", i), 32'(rsp_flags), 32'(tv[i].f));
         chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(tv[i].e));
         chk($sformatf("v%0d_op_count", i), 32'(op_count), 32'(i + 1));
         chk($sformatf("v%0d_sticky", i), 32'({sticky_carry, sticky_ovf}), 32'({exp_sc, exp_so}));
      end

      sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      chk("clr_sticky", 32'({sticky_carry, sticky_ovf}), 0);
      chk("clr_rsp_dropped", 32'(rsp_valid), 0);

      // Clear coincident with an overflowing capture: only the new flags remain.
      push(3'd1, 4'h0, 4'h1);
      step();
      chk("pre_clr_sticky", 32'({sticky_carry, sticky_ovf}), 32'(2'b10));
      push(3'd0, 4'h7, 4'h1);
      sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      chk("clr_cap_sticky", 32'({sticky_carry, sticky_ovf}), 32'(2'b01));
      chk("clr_cap_data", 32'(rsp_data), 8);

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Backpressure: fill the FIFO behind a held response, then drain.
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(3'd0, 4'(i), 4'h1);
      chk("bp_level_full", 32'(level), 4);
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
      chk("bp_head_frozen", 32'(rsp_data), 1);
      cmd_sel = 3'd0; cmd_a = 4'hC; cmd_b = 4'h0; cmd_valid = 1'b1;
      step();
      chk("bp_no_push_full", 32'(level), 4);
      chk("bp_still_frozen", 32'({rsp_valid, rsp_data}), 32'({1'b1, 4'h1}));
      chk("bp_alu_head", 32'({alu_a, alu_b}), 32'({4'h1, 4'h1}));
      rsp_ready = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("drain0_data", 32'(rsp_data), 2);
      chk("drain0_level", 32'(level), 3);
      for (int i = 1; i < 4; i++) begin
         step();
         chk($sformatf("drain%0d_data", i), 32'(rsp_data), 32'(i + 2));
         chk($sformatf("drain%0d_level", i), 32'(level), 32'(3 - i));
         chk($sformatf("drain%0d_valid", i), 32'(rsp_valid), 1);
      end
      chk("drain_op_count", 32'(op_count), 5);
      step();
      chk("drain_idle", 32'(rsp_valid), 0);
      chk("drain_hold_data", 32'(rsp_data), 5);

      // Asynchronous reset with queued commands and a held response.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(3'd5, 4'(i), 4'h8);
      chk("mid_level", 32'(level), 2);
      chk("mid_valid", 32'(rsp_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(rsp_valid), 0);
      chk("async_rst_level", 32'(level), 0);
      chk("async_rst_cnt", 32'(op_count), 0);
      chk("async_rst_rsp", 32'({rsp_data, rsp_flags, rsp_err}), 0);
      chk("async_rst_alu", 32'({alu_select, alu_a, alu_b}), 0);
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_rst_quiet%0d", i), 32'({rsp_valid, level, op_count}), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
